// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch stage between the PC register and the decoder.
// Issues one word-aligned request at a time to instruction memory
// (req/gnt/rvalid) and buffers each returned word, together with its PC,
// in a DEPTH-entry FIFO. A redirect flushes the FIFO and marks any
// in-flight response as stale so it is dropped when it returns.
//
// Build option: define FETCH_ALIGN_CHECK_EN to turn a misaligned fetch
// address into a faulting queue entry instead of a memory request.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_valid,
    output logic          pc_ack,
    input  logic          redirect,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic [AW-1:0] inst_pc,
    output logic          inst_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // Memory-side transaction tracker: idle, waiting for a live response,
    // or waiting for a response that a redirect has made stale.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    fetch_state_t    state;
    logic [AW-1:0]   req_pc;

    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic [31:0]     q_inst  [DEPTH];
    logic [AW-1:0]   q_pc    [DEPTH];
    logic [DEPTH-1:0] q_fault;

    logic            outstanding;
    logic            drop;
    logic            has_space;
    logic            misaligned;
    logic            can_issue;
    logic            fault_take;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic [31:0]     push_inst;
    logic [AW-1:0]   push_pc;
    logic            push_fault;

    assign outstanding = (state != S_IDLE);
    assign drop        = (state == S_DROP);

    // Room is counted including the request still in flight, so a returning
    // response always has a free slot waiting for it.
    assign has_space = (count + CW'(outstanding)) < CW'(DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Gating with reset keeps the handshake quiet while the block is held
    // in reset, even if the PC stage is already presenting an address.
    assign can_issue  = reset & pc_valid & ~redirect & ~outstanding & has_space;
    assign imem_req   = can_issue & ~misaligned;
    assign fault_take = can_issue & misaligned;
    assign imem_addr  = {pc_in[AW-1:2], 2'b00};
    assign pc_ack     = (imem_req & imem_gnt) | fault_take;

    // A response is only kept if it belongs to the live request and the
    // same cycle is not flushing the queue.
    assign rsp_take = imem_rvalid & outstanding & ~drop & ~redirect;
    assign push     = rsp_take | fault_take;
    assign pop      = inst_valid & inst_ready & ~redirect;

    // Fault entries and memory responses never coincide: a fault needs no
    // outstanding request, a response needs one.
    assign push_inst  = fault_take ? 32'h0 : imem_rdata;
    assign push_pc    = fault_take ? pc_in : req_pc;
    assign push_fault = fault_take;

    // Head of the queue drives the decoder directly; no bypass from memory.
    assign inst_valid = (count != '0);
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];
    assign inst_fault = q_fault[rd_ptr];

    // Track the single outstanding request and whether its response is stale.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            req_pc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (imem_req && imem_gnt) begin
                        state  <= S_WAIT;
                        req_pc <= pc_in;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state <= S_IDLE;
                    end else if (redirect) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail.
    // NOTE: the storage is reset as well so the head outputs read zero
    // during reset instead of whatever was last buffered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
            q_fault <= '0;
        end else if (push) begin
            q_inst[wr_ptr]  <= push_inst;
            q_pc[wr_ptr]    <= push_pc;
            q_fault[wr_ptr] <= push_fault;
        end
    end

    // Structural invariants of the queue and the issue handshake.
    a_count_bound : assert property (@(posedge clk) disable iff (!reset)
        count <= CW'(DEPTH));
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        (push && !pop) |-> (count < CW'(DEPTH)));
    a_ack_not_on_redirect : assert property (@(posedge clk) disable iff (!reset)
        redirect |-> !pc_ack);
    a_req_aligned : assert property (@(posedge clk) disable iff (!reset)
        imem_req |-> (imem_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue. A behavioural model (an entry
// queue plus outstanding/stale flags) predicts every output each cycle; a
// small memory model answers granted requests after a random delay.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic          pc_valid;
    logic          pc_ack;
    logic          redirect;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;
    logic          inst_fault;

    inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ack      (pc_ack),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_fault  (inst_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [31:0]   word;
        logic [AW-1:0] pc;
        logic          fault;
    } entry_t;

    entry_t        mq[$];
    bit            m_out;
    bit            m_drop;
    logic [AW-1:0] m_req_pc;

    // Memory model and PC stage
    bit            mem_pend;
    int            mem_delay;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] pc_cur;
    bit            force_stray;
    bit            did_reset;

    // Stimulus knobs (percent probabilities)
    int p_valid, p_gnt, p_rv, p_ready, p_redir, p_stray, max_delay;

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic logic [AW-1:0] new_target();
        logic [AW-1:0] t;
        t = $urandom;
        t[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return t;
    endfunction

    // One clock cycle: drive at the falling edge, check just after, advance
    // the model to what the next rising edge must produce.
    task automatic run_cycle();
        logic   misal, can, exp_req, fault_ack, exp_ack, rv;
        entry_t e;

        pc_valid   = pct(p_valid);
        pc_in      = pc_cur;
        redirect   = pct(p_redir);
        imem_gnt   = pct(p_gnt);
        inst_ready = pct(p_ready);
        if (mem_pend) begin
            if (mem_delay == 0 && pct(p_rv)) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(mem_addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end else begin
            imem_rvalid = force_stray || pct(p_stray);
            imem_rdata  = $urandom;
        end
        force_stray = 1'b0;

        #1;
        check("inst_valid", inst_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("inst", inst, mq[0].word);
            check("inst_pc", inst_pc, mq[0].pc);
            check("inst_fault", inst_fault, mq[0].fault);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        misal = (pc_in[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        can       = pc_valid && !redirect && !m_out && (mq.size() < DEPTH);
        exp_req   = can && !misal;
        fault_ack = can && misal;
        exp_ack   = (exp_req && imem_gnt) || fault_ack;
        check("imem_req", imem_req, exp_req);
        check("pc_ack", pc_ack, exp_ack);
        check("imem_addr", imem_addr, {pc_in[AW-1:2], 2'b00});

        // Model update
        rv = imem_rvalid && m_out;
        if (redirect) begin
            mq.delete();
        end else if (mq.size() != 0 && inst_ready) begin
            void'(mq.pop_front());
        end
        if (rv) begin
            if (!m_drop && !redirect) begin
                e.word  = word_of({m_req_pc[AW-1:2], 2'b00});
                e.pc    = m_req_pc;
                e.fault = 1'b0;
                mq.push_back(e);
            end
            m_out  = 1'b0;
            m_drop = 1'b0;
        end else if (redirect && m_out) begin
            m_drop = 1'b1;
        end
        if (fault_ack) begin
            e.word  = 32'h0;
            e.pc    = pc_in;
            e.fault = 1'b1;
            mq.push_back(e);
        end

        // Memory model
        if (mem_pend) begin
            if (imem_rvalid) mem_pend = 1'b0;
            else if (mem_delay > 0) mem_delay--;
        end
        if (exp_req && imem_gnt) begin
            m_out     = 1'b1;
            m_req_pc  = pc_in;
            mem_pend  = 1'b1;
            mem_addr  = {pc_in[AW-1:2], 2'b00};
            mem_delay = $urandom_range(0, max_delay);
        end

        // PC stage
        if (redirect) pc_cur = new_target();
        else if (exp_ack) pc_cur = pc_cur + 4;

        @(negedge clk);
    endtask

    // Asynchronous reset pulse in the middle of a cycle, then a stray rvalid.
    task automatic do_async_reset();
        pc_valid    = 1'b1;
        pc_in       = pc_cur;
        redirect    = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        inst_ready  = 1'b0;
        #1;
        check("pre_reset_valid", inst_valid, mq.size() != 0);
        #1 reset = 1'b0;
        #1;
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, '0);
        check("rst_inst_fault", inst_fault, 1'b0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_pc_ack", pc_ack, 1'b0);
        mq.delete();
        m_out    = 1'b0;
        m_drop   = 1'b0;
        mem_pend = 1'b0;
        @(negedge clk);
        reset       = 1'b1;
        force_stray = 1'b1;
        did_reset   = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        pc_valid    = 1'b1;
        pc_in       = '0;
        redirect    = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b1;
        pc_cur      = '0;
        m_out       = 1'b0;
        m_drop      = 1'b0;
        m_req_pc    = '0;
        mem_pend    = 1'b0;
        mem_delay   = 0;
        mem_addr    = '0;
        force_stray = 1'b0;
        did_reset   = 1'b0;

        #3;
        check("init_inst_valid", inst_valid, 1'b0);
        check("init_inst", inst, 32'h0);
        check("init_inst_pc", inst_pc, '0);
        check("init_inst_fault", inst_fault, 1'b0);
        check("init_imem_req", imem_req, 1'b0);
        check("init_pc_ack", pc_ack, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Phase 0: streaming at minimum latency from PC 0.
        p_valid = 100; p_gnt = 100; p_rv = 100; p_ready = 100;
        p_redir = 0; p_stray = 0; max_delay = 0;
        for (int i = 0; i < 24; i++) run_cycle();

        // Phase 1: slow decoder so the queue fills; reset pulse at count 3.
        p_valid = 90; p_gnt = 80; p_rv = 70; p_ready = 15;
        p_redir = 3; p_stray = 3; max_delay = 2;
        for (int i = 0; i < 400; i++) begin
            if (!did_reset && mq.size() == 3) do_async_reset();
            else run_cycle();
        end
        if (!did_reset) do_async_reset();

        // Phase 2: general random traffic.
        p_valid = 85; p_gnt = 70; p_rv = 60; p_ready = 60;
        p_redir = 8; p_stray = 5; max_delay = 3;
        for (int i = 0; i < 2000; i++) run_cycle();

        // Phase 3: frequent redirects against in-flight responses.
        p_valid = 90; p_gnt = 80; p_rv = 50; p_ready = 70;
        p_redir = 25; p_stray = 5; max_delay = 3;
        for (int i = 0; i < 600; i++) run_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Fetch stage directly downstream of the program-counter register.
- Accepts the current fetch address from the PC stage with a valid/ready handshake and issues it to the instruction memory through a req/gnt/rvalid interface.
- Buffers returned instruction words, each with its PC, in a small FIFO feeding the decoder.
- A redirect (taken branch, jump, jr, ILLOP/XADR exception entry) flushes the queue and discards any in-flight response.

Parameters:
- DEPTH, 4, number of instruction queue entries; power of two, 2..16.
- AW, 32, address / PC width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_in  input  AW  fetch address presented by the PC stage.
- pc_valid  input  1  pc_in is valid this cycle.
- pc_ack  output  1  address accepted this cycle; the PC stage advances on pc_valid & pc_ack.
- redirect  input  1  flush: drop queue contents and any outstanding response.
- imem_req  output  1  memory request valid.
- imem_addr  output  AW  memory word address (pc_in with [1:0] forced to 0).
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decoder consumes the head.
- inst  output  32  head instruction word.
- inst_pc  output  AW  head instruction address.
- inst_fault  output  1  head entry carries a misalignment fault (feature only; 0 otherwise).

Behaviour:
- Reset (reset=0, asynchronous): queue empty, count=0, outstanding=0, drop=0, rd/wr pointers 0. Outputs: inst_valid=0, inst=0, inst_pc=0, inst_fault=0, imem_req=0, pc_ack=0.
- Issue rule:
  - imem_req = pc_valid & ~redirect & ~outstanding & (count + outstanding < DEPTH).
  - imem_addr = {pc_in[AW-1:2], 2'b00}.
  - pc_ack = imem_req & imem_gnt (combinational).
  - On acceptance: outstanding<=1 and the accepted pc is latched as req_pc.
  - At most one outstanding request.
- Response: on imem_rvalid & outstanding & ~drop, write {imem_rdata, req_pc, fault=0} at wr_ptr, increment wr_ptr, clear outstanding. Minimum latency: gnt in cycle N, rvalid in cycle N+1 earliest, inst_valid in cycle N+2.
- Dequeue: on inst_valid & inst_ready, increment rd_ptr. inst, inst_pc and inst_fault are read from the head entry.
- Simultaneous write and dequeue: count unchanged; a full queue accepts the write because the pop frees a slot the same cycle.
- Empty: inst_valid=0. A response is never bypassed to the output in the same cycle it arrives.
- Full: imem_req=0, pc_ack=0, so the PC stage holds.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
- Redirect (takes priority over every other event that cycle):
  - count<=0 and pointers reset to 0.
  - A dequeue in the same cycle is ignored.
  - If outstanding=1 and no rvalid arrives this cycle, drop<=1.
  - pc_ack is forced to 0 so the new target is issued at the earliest in the next cycle.
- Stale response: on rvalid with drop=1, data is discarded and drop<=0, outstanding<=0.
- rvalid with outstanding=0 is ignored.
- Reset mid-transaction: all state cleared. Memory must also be reset; a late rvalid is ignored because outstanding=0.
- The kernel bit pc[31] is carried through unchanged in inst_pc.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - If pc_in[1:0]!=0 with pc_valid, no memory request is made.
  - pc_ack=1 immediately, provided there is queue space and outstanding=0.
  - An entry {inst=32'h0, inst_pc=pc_in, fault=1} is written directly.
  - The decoder turns the fault into an ILLOP redirect.
- Undefined: pc_in[1:0] is ignored, the word at the aligned address is fetched, and inst_fault is tied to 0.

Test Plan:
- Reset with pc_valid=1, pc_in=32'h00000000, gnt always 1, rvalid one cycle after gnt, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8 with matching words; first inst_valid 2 cycles after first gnt; one instruction every 2 cycles.
- inst_ready=0 with DEPTH=4 -> after 4 responses, imem_req=0 and pc_ack=0; assert inst_ready for 1 cycle -> one dequeue, then exactly one new request.
- Request accepted at 0x40, redirect asserted the next cycle before rvalid, new pc_in=0x80000004 -> the 0x40 response is discarded and the next inst_pc=0x80000004.
- Redirect in the same cycle as rvalid and inst_ready with count=2 -> queue empty next cycle; the response is not enqueued; drop stays 0.
- reset pulsed low mid-stream with count=3 -> outputs zero immediately (asynchronously); a subsequent stray rvalid does not create an entry.
- FETCH_ALIGN_CHECK_EN defined, pc_in=32'h00000102 -> no imem_req; entry with inst_fault=1, inst_pc=0x102, inst=0. Macro undefined -> imem_addr=0x100 and inst_fault=0.
